vector_address_unit: RTL and testbench

Parametrised vector load/store address generator for the vector LSU. It accepts one memory instruction per start pulse and produces the per-element byte addresses and byte enables on a request/grant memory port, tracking outstanding responses until all `vl` elements complete. It supports unit-stride, strided (signed stride) and indexed addressing. It sits between the vector decode/CSR stage (`vsew`, `vl`) and the data memory interface.

---
 rtl/ava_pkg.sv | 25 ++
 rtl/vector_address_unit_if.sv | 24 ++
 rtl/au_be_gen.sv | 32 +++
 rtl/vector_address_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_vector_address_unit.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ava_pkg.sv
// Shared types for the vector address unit: addressing modes, element
// widths and controller states.
package ava_pkg;

  typedef enum logic [1:0] {
    UNIT      = 2'd0,
    STRIDED   = 2'd1,
    INDEXED   = 2'd2,
    MODE_RSVD = 2'd3
  } au_mode_e;

  typedef enum logic [1:0] {
    SEW8     = 2'd0,
    SEW16    = 2'd1,
    SEW32    = 2'd2,
    SEW_RSVD = 2'd3
  } vsew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } au_state_e;

endpackage

// File: rtl/vector_address_unit_if.sv
// Request/grant data memory port of the vector address unit.
//   master: drives data_req, data_addr, data_be, elem_idx; receives data_gnt, data_rvalid
//   slave : the memory side of the same port
interface vector_address_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned VL_W   = 7
);
  logic              data_req;
  logic              data_gnt;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_be;
  logic [VL_W-1:0]   elem_idx;
  logic              data_rvalid;

  modport master (
    output data_req, data_addr, data_be, elem_idx,
    input  data_gnt, data_rvalid
  );

  modport slave (
    input  data_req, data_addr, data_be, elem_idx,
    output data_gnt, data_rvalid
  );
endinterface

// File: rtl/au_be_gen.sv
// Byte-enable and alignment decode for one element.
//   addr_lo_i : address bits [1:0]
//   sew_i     : element width (8/16/32 bit)
//   be_o      : byte enables within the 32-bit word
//   misal_o   : address is not a multiple of the element size
module au_be_gen
  import ava_pkg::*;
(
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] sew_i,
  output logic [3:0] be_o,
  output logic       misal_o
);

  always_comb begin
    be_o    = 4'h0;
    misal_o = 1'b0;
    case (sew_i)
      SEW8:  be_o = 4'b0001 << addr_lo_i;
      SEW16: begin
        be_o    = 4'b0011 << addr_lo_i;
        misal_o = addr_lo_i[0];
      end
      SEW32: begin
        be_o    = 4'b1111 << addr_lo_i;
        misal_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_address_unit.sv
// Vector load/store address generator: per start pulse, walks vl elements in
// unit-stride, strided or indexed mode, issues them on a request/grant port and
// waits for all responses before pulsing done.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   au_start_i          : start pulse (only seen in IDLE)
//   mode_i, vsew_i, vl_i: addressing mode, element width, element count
//   base_addr_i         : base byte address
//   stride_i            : signed byte stride (strided)
//   idx_i, idx_valid_i, idx_ready_o : byte offset stream (indexed)
//   mem                 : memory request port (req/gnt/addr/be/elem_idx/rvalid)
//   au_busy_o, au_done_o, au_err_o  : status
// Build option: define AU_INDEXED_EN to include indexed mode; otherwise mode 2
// is reserved and idx_ready_o is tied low.
module vector_address_unit
  import ava_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned VL_W    = 7,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  au_start_i,
  input  logic [1:0]            mode_i,
  input  logic [1:0]            vsew_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     stride_i,
  input  logic [ADDR_W-1:0]     idx_i,
  input  logic                  idx_valid_i,
  output logic                  idx_ready_o,
  vector_address_unit_if.master mem,
  output logic                  au_busy_o,
  output logic                  au_done_o,
  output logic                  au_err_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        sew_q, sew_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              slot_q, slot_d;   // address register holds an unissued element
  logic [VL_W-1:0]   elem_q, elem_d;   // granted-element count
  logic [OUT_W-1:0]  out_q, out_d;     // granted but unanswered
  logic              err_q, err_d;
  logic [3:0]        be_q;
  logic              misal_q;
  logic              req_q, req_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              erro_q, erro_d;
  logic [3:0]        be_c;
  logic              misal_c;
  logic              gnt_c, rv_c, start_rsvd_c;

`ifdef AU_INDEXED_EN
  logic [ADDR_W-1:0] base_q, base_d;
`else
  logic unused_idx;
  assign unused_idx = ^{idx_i, idx_valid_i};
`endif

  // Decode of the next address so BE and alignment are registered alongside it
  au_be_gen u_be_gen (
    .addr_lo_i (addr_d[1:0]),
    .sew_i     (sew_d),
    .be_o      (be_c),
    .misal_o   (misal_c)
  );

  assign gnt_c = req_q & mem.data_gnt;
  assign rv_c  = mem.data_rvalid & (out_q != '0);

`ifdef AU_INDEXED_EN
  assign start_rsvd_c = (mode_i == MODE_RSVD) || (vsew_i == SEW_RSVD);
`else
  assign start_rsvd_c = (mode_i == MODE_RSVD) || (mode_i == INDEXED) || (vsew_i == SEW_RSVD);
`endif

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sew_d    = sew_q;
    vl_d     = vl_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    slot_d   = slot_q;
    elem_d   = elem_q;
    err_d    = err_q;
    done_d   = 1'b0;
    out_d    = out_q + OUT_W'(gnt_c) - OUT_W'(rv_c);
`ifdef AU_INDEXED_EN
    base_d   = base_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (au_start_i) begin
          mode_d   = mode_i;
          sew_d    = vsew_i;
          vl_d     = vl_i;
          stride_d = stride_i;
          addr_d   = base_addr_i;
`ifdef AU_INDEXED_EN
          base_d   = base_addr_i;
`endif
          elem_d   = '0;
          err_d    = start_rsvd_c;
          slot_d   = (mode_i != INDEXED);
          // Nothing to issue: skip straight to the drain/done path
          state_d  = (start_rsvd_c || (vl_i == '0)) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (slot_q && misal_q) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else if (gnt_c) begin
          elem_d = elem_q + VL_W'(1);
          if (elem_q == vl_q - VL_W'(1)) begin
            state_d = ST_DRAIN;
          end
          case (mode_q)
            UNIT:    addr_d = addr_q + (ADDR_W'(1) << sew_q);
            STRIDED: addr_d = addr_q + stride_q;
            default: slot_d = 1'b0;
          endcase
`ifdef AU_INDEXED_EN
        end else if (rdy_q && idx_valid_i) begin
          addr_d = base_q + idx_i;
          slot_d = 1'b1;
`endif
        end
      end
      ST_DRAIN: begin
        if (out_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the next register values
  always_comb begin
    req_d  = (state_d == ST_ISSUE) && slot_d && (elem_d < vl_d) &&
             (out_d < OUT_W'(MAX_OUT)) && !misal_c;
`ifdef AU_INDEXED_EN
    rdy_d  = (state_d == ST_ISSUE) && !slot_d && (elem_d < vl_d);
`else
    rdy_d  = 1'b0;
`endif
    busy_d = (state_d != ST_IDLE);
    erro_d = done_d && err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      sew_q    <= '0;
      vl_q     <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      slot_q   <= 1'b0;
      elem_q   <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      be_q     <= '0;
      misal_q  <= 1'b0;
      req_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
`ifdef AU_INDEXED_EN
      base_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sew_q    <= sew_d;
      vl_q     <= vl_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      slot_q   <= slot_d;
      elem_q   <= elem_d;
      out_q    <= out_d;
      err_q    <= err_d;
      be_q     <= be_c;
      misal_q  <= misal_c;
      req_q    <= req_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
`ifdef AU_INDEXED_EN
      base_q   <= base_d;
`endif
    end
  end

  assign mem.data_req  = req_q;
  assign mem.data_addr = addr_q;
  assign mem.data_be   = be_q;
  assign mem.elem_idx  = elem_q;
  assign idx_ready_o   = rdy_q;
  assign au_busy_o     = busy_q;
  assign au_done_o     = done_q;
  assign au_err_o      = erro_q;

endmodule

// File: tb/tb_vector_address_unit.sv
// Directed bench for vector_address_unit: a small memory model grants and
// answers requests while each task checks addresses, enables and status.
module tb_vector_address_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode, sew;
  logic [6:0]  vl;
  logic [31:0] base, stride, idx;
  logic        idx_valid, idx_ready, busy, done, err;

  vector_address_unit_if #(.ADDR_W(32), .VL_W(7)) mem_if ();

  vector_address_unit #(.ADDR_W(32), .VL_W(7), .MAX_OUT(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .au_start_i  (start),
    .mode_i      (mode),
    .vsew_i      (sew),
    .vl_i        (vl),
    .base_addr_i (base),
    .stride_i    (stride),
    .idx_i       (idx),
    .idx_valid_i (idx_valid),
    .idx_ready_o (idx_ready),
    .mem         (mem_if),
    .au_busy_o   (busy),
    .au_done_o   (done),
    .au_err_o    (err)
  );

  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          done_cnt = 0;
  int          req_cycles = 0;
  bit          gnt_seen = 1'b0;
  bit          auto_rv = 1'b0;
  bit          man_rv = 1'b0;
  logic [31:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic [6:0]  log_elem[$];

  // Mid-cycle monitor: records requests that will be granted at the next edge
  always @(negedge clk) begin
    gnt_seen = mem_if.data_req && mem_if.data_gnt;
    if (gnt_seen) begin
      log_addr.push_back(mem_if.data_addr);
      log_be.push_back(mem_if.data_be);
      log_elem.push_back(mem_if.elem_idx);
    end
    if (mem_if.data_req) req_cycles++;
    if (done) done_cnt++;
  end

  // Response driver: either one cycle after each grant, or under task control
  always @(posedge clk) begin
    #2;
    mem_if.data_rvalid = auto_rv ? gnt_seen : man_rv;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_be.delete();
    log_elem.delete();
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] s, input logic [6:0] v,
                          input logic [31:0] b, input logic [31:0] st);
    start = 1'b1; mode = m; sew = s; vl = v; base = b; stride = st;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        chk_cnt++;
        return;
      end
      step();
    end
    chk_cnt++;
    err_cnt++;
    $display("FAIL %s_timeout: no done within %0d cycles, required a done pulse", name, budget);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = '0; sew = '0; vl = '0; base = '0; stride = '0;
    idx = '0; idx_valid = 1'b0; mem_if.data_gnt = 1'b0;
    step(); step();
    chk_cnt++; if (mem_if.data_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %b want 0", mem_if.data_req); end
    chk_cnt++; if (mem_if.data_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr: got %h want 0", mem_if.data_addr); end
    chk_cnt++; if (mem_if.data_be !== 4'h0) begin err_cnt++; $display("FAIL rst_be: got %h want 0", mem_if.data_be); end
    chk_cnt++; if (mem_if.elem_idx !== 7'h0) begin err_cnt++; $display("FAIL rst_elem: got %h want 0", mem_if.elem_idx); end
    chk_cnt++; if (idx_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_idx_ready: got %b want 0", idx_ready); end
    chk_cnt++; if ({busy, done, err} !== 3'b000) begin err_cnt++; $display("FAIL rst_status: got %b want 000", {busy, done, err}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unit();
    int d0;
    clear_log();
    mem_if.data_gnt = 1'b1; auto_rv = 1'b1;
    d0 = done_cnt;
    do_start(2'd0, 2'd0, 7'd16, 32'h1000, 32'h0);
    chk_cnt++; if (mem_if.data_req !== 1'b1) begin err_cnt++; $display("FAIL unit_req_latency: got %b want 1", mem_if.data_req); end
    wait_done(60, "unit");
    chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL unit_err: got %b want 0", err); end
    step(); step();
    chk_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL unit_done_count: got %0d want 1", done_cnt - d0); end
    chk_cnt++; if (log_addr.size() !== 16) begin err_cnt++; $display("FAIL unit_count: got %0d want 16", log_addr.size()); end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      logic [31:0] ea;
      logic [3:0]  eb;
      ea = 32'h1000 + 32'(i);
      eb = 4'b0001 << (i % 4);
      chk_cnt++; if (log_addr[i] !== ea) begin err_cnt++; $display("FAIL unit_addr[%0d]: got %h want %h", i, log_addr[i], ea); end
      chk_cnt++; if (log_be[i] !== eb) begin err_cnt++; $display("FAIL unit_be[%0d]: got %h want %h", i, log_be[i], eb); end
      chk_cnt++; if (log_elem[i] !== 7'(i)) begin err_cnt++; $display("FAIL unit_elem[%0d]: got %0d want %0d", i, log_elem[i], i); end
    end
  endtask

  task automatic test_strided();
    clear_log();
    mem_if.data_gnt = 1'b1; auto_rv = 1'b1;
    do_start(2'd1, 2'd0, 7'd16, 32'h2000, 32'd2);
    wait_done(60, "strided");
    chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL stride_err: got %b want 0", err); end
    step();
    chk_cnt++; if (log_addr.size() !== 16) begin err_cnt++; $display("FAIL stride_count: got %0d want 16", log_addr.size()); end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      logic [31:0] ea;
      logic [3:0]  eb;
      ea = 32'h2000 + 32'(2 * i);
      eb = (i % 2 == 0) ? 4'h1 : 4'h4;
      chk_cnt++; if (log_addr[i] !== ea) begin err_cnt++; $display("FAIL stride_addr[%0d]: got %h want %h", i, log_addr[i], ea); end
      chk_cnt++; if (log_be[i] !== eb) begin err_cnt++; $display("FAIL stride_be[%0d]: got %h want %h", i, log_be[i], eb); end
    end
  endtask

  task automatic test_neg_stride();
    logic [31:0] wrap_exp[3];
    clear_log();
    mem_if.data_gnt = 1'b1; auto_rv = 1'b1;
    do_start(2'd1, 2'd2, 7'd5, 32'h10, 32'hFFFF_FFFC);
    wait_done(40, "neg_stride");
    step();
    chk_cnt++; if (log_addr.size() !== 5) begin err_cnt++; $display("FAIL neg_count: got %0d want 5", log_addr.size()); end
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      logic [31:0] ea;
      ea = 32'h10 - 32'(4 * i);
      chk_cnt++; if (log_addr[i] !== ea) begin err_cnt++; $display("FAIL neg_addr[%0d]: got %h want %h", i, log_addr[i], ea); end
      chk_cnt++; if (log_be[i] !== 4'hF) begin err_cnt++; $display("FAIL neg_be[%0d]: got %h want F", i, log_be[i]); end
    end
    clear_log();
    wrap_exp[0] = 32'h4; wrap_exp[1] = 32'h0; wrap_exp[2] = 32'hFFFF_FFFC;
    do_start(2'd1, 2'd2, 7'd3, 32'h4, 32'hFFFF_FFFC);
    wait_done(40, "wrap");
    step();
    chk_cnt++; if (log_addr.size() !== 3) begin err_cnt++; $display("FAIL wrap_count: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk_cnt++; if (log_addr[i] !== wrap_exp[i]) begin err_cnt++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, log_addr[i], wrap_exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    mem_if.data_gnt = 1'b1; auto_rv = 1'b0; man_rv = 1'b0;
    do_start(2'd0, 2'd2, 7'd4, 32'h40, 32'h0);
    repeat (5) step();
    chk_cnt++; if (log_addr.size() !== 2) begin err_cnt++; $display("FAIL bp_two_grants: got %0d want 2", log_addr.size()); end
    chk_cnt++; if (mem_if.data_req !== 1'b0) begin err_cnt++; $display("FAIL bp_req_low: got %b want 0", mem_if.data_req); end
    man_rv = 1'b1; step(); man_rv = 1'b0;
    repeat (5) step();
    chk_cnt++; if (log_addr.size() !== 3) begin err_cnt++; $display("FAIL bp_one_more: got %0d want 3", log_addr.size()); end
    chk_cnt++; if (mem_if.data_req !== 1'b0) begin err_cnt++; $display("FAIL bp_req_low2: got %b want 0", mem_if.data_req); end
    mem_if.data_gnt = 1'b0;
    man_rv = 1'b1; step(); man_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++; if (mem_if.data_req !== 1'b1) begin err_cnt++; $display("FAIL bp_hold_req[%0d]: got %b want 1", k, mem_if.data_req); end
      chk_cnt++; if (mem_if.data_addr !== 32'h4C) begin err_cnt++; $display("FAIL bp_hold_addr[%0d]: got %h want 4c", k, mem_if.data_addr); end
      chk_cnt++; if (mem_if.elem_idx !== 7'd3) begin err_cnt++; $display("FAIL bp_hold_elem[%0d]: got %0d want 3", k, mem_if.elem_idx); end
      step();
    end
    mem_if.data_gnt = 1'b1;
    step();
    chk_cnt++; if (log_addr.size() !== 4) begin err_cnt++; $display("FAIL bp_final_count: got %0d want 4", log_addr.size()); end
    else begin
      chk_cnt++; if (log_addr[3] !== 32'h4C) begin err_cnt++; $display("FAIL bp_final_addr: got %h want 4c", log_addr[3]); end
    end
    man_rv = 1'b1; step(); step(); man_rv = 1'b0;
    wait_done(10, "bp");
    chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL bp_err: got %b want 0", err); end
    step();
  endtask

  task automatic test_edge();
    int r0;
    mem_if.data_gnt = 1'b1; auto_rv = 1'b1;
    r0 = req_cycles;
    do_start(2'd0, 2'd0, 7'd0, 32'h0, 32'h0);
    chk_cnt++; if ({busy, done} !== 2'b10) begin err_cnt++; $display("FAIL vl0_t1: got busy/done %b want 10", {busy, done}); end
    step();
    chk_cnt++; if ({done, err} !== 2'b10) begin err_cnt++; $display("FAIL vl0_done: got done/err %b want 10", {done, err}); end
    step();
    chk_cnt++; if ({busy, done} !== 2'b00) begin err_cnt++; $display("FAIL vl0_pulse: got busy/done %b want 00", {busy, done}); end
    do_start(2'd0, 2'd2, 7'd4, 32'h1002, 32'h0);
    wait_done(10, "misalign");
    chk_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL misalign_err: got %b want 1", err); end
    step();
    do_start(2'd0, 2'd3, 7'd4, 32'h1000, 32'h0);
    step();
    chk_cnt++; if ({done, err} !== 2'b11) begin err_cnt++; $display("FAIL sew3: got done/err %b want 11", {done, err}); end
    step();
    do_start(2'd3, 2'd0, 7'd4, 32'h1000, 32'h0);
    step();
    chk_cnt++; if ({done, err} !== 2'b11) begin err_cnt++; $display("FAIL mode3: got done/err %b want 11", {done, err}); end
    step();
`ifndef AU_INDEXED_EN
    do_start(2'd2, 2'd2, 7'd4, 32'h1000, 32'h0);
    chk_cnt++; if (idx_ready !== 1'b0) begin err_cnt++; $display("FAIL mode2_ready: got %b want 0", idx_ready); end
    step();
    chk_cnt++; if ({done, err} !== 2'b11) begin err_cnt++; $display("FAIL mode2_rsvd: got done/err %b want 11", {done, err}); end
    step();
`endif
    chk_cnt++; if (req_cycles !== r0) begin err_cnt++; $display("FAIL edge_no_req: got %0d req cycles want 0", req_cycles - r0); end
  endtask

`ifdef AU_INDEXED_EN
  task automatic feed_idx(input logic [31:0] v);
    bit hs;
    hs = 1'b0;
    idx = v; idx_valid = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      if (idx_ready) hs = 1'b1;
      step();
    end
    idx_valid = 1'b0;
    chk_cnt++; if (!hs) begin err_cnt++; $display("FAIL idx_handshake: no ready for %h within 20 cycles", v); end
  endtask

  task automatic test_indexed();
    logic [31:0] ea[3];
    int d0;
    ea[0] = 32'h100; ea[1] = 32'h108; ea[2] = 32'h104;
    clear_log();
    mem_if.data_gnt = 1'b1; auto_rv = 1'b1;
    do_start(2'd2, 2'd2, 7'd3, 32'h100, 32'h0);
    feed_idx(32'h0); feed_idx(32'h8); feed_idx(32'h4);
    wait_done(20, "indexed");
    chk_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL idx_err: got %b want 0", err); end
    step();
    chk_cnt++; if (log_addr.size() !== 3) begin err_cnt++; $display("FAIL idx_count: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk_cnt++; if (log_addr[i] !== ea[i]) begin err_cnt++; $display("FAIL idx_addr[%0d]: got %h want %h", i, log_addr[i], ea[i]); end
      chk_cnt++; if (log_be[i] !== 4'hF) begin err_cnt++; $display("FAIL idx_be[%0d]: got %h want F", i, log_be[i]); end
    end
    // Reset in the middle of an indexed operation
    clear_log();
    do_start(2'd2, 2'd2, 7'd3, 32'h100, 32'h0);
    feed_idx(32'h0); feed_idx(32'h8);
    for (int c = 0; c < 10 && log_addr.size() < 2; c++) step();
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk_cnt++; if ({mem_if.data_req, idx_ready, busy, done, err} !== 5'b0) begin err_cnt++; $display("FAIL midrst_ctl: got %b want 00000", {mem_if.data_req, idx_ready, busy, done, err}); end
    chk_cnt++; if ({mem_if.data_addr, mem_if.data_be, mem_if.elem_idx} !== 43'b0) begin err_cnt++; $display("FAIL midrst_bus: got %h/%h/%h want 0", mem_if.data_addr, mem_if.data_be, mem_if.elem_idx); end
    rst = 1'b0;
    repeat (3) step();
    chk_cnt++; if (done_cnt !== d0) begin err_cnt++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
    clear_log();
    do_start(2'd0, 2'd2, 7'd1, 32'h200, 32'h0);
    wait_done(20, "post_reset");
    step();
    chk_cnt++; if (log_addr.size() !== 1 || log_addr[0] !== 32'h200) begin err_cnt++; $display("FAIL post_reset_addr: got %0d reqs, want one at 200", log_addr.size()); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unit();
    test_strided();
    test_neg_stride();
    test_backpressure();
    test_edge();
`ifdef AU_INDEXED_EN
    test_indexed();
`endif
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
